// File: rtl/data_mem_unit_if.sv
// Request/response bus for data_mem_unit: one load/store request in, one response out.
// The master drives requests and rsp_ready; the slave (the memory) drives the rest.
interface data_mem_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_unit.sv
// Byte-lane data memory with sized, sign/zero-extending loads and lane-masked stores.
// One request in flight: IDLE accepts, ACCESS reads/writes the RAM, RESP holds the answer.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// ACCESS | captured request; RAM read, store commits on the exit edge
// RESP   | response presented until rsp_ready
module data_mem_unit #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  data_mem_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_word;
  logic [31:0] mem [DEPTH];

  logic          accept;
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          err;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic          commit;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_data;

  assign accept = bus.req_valid && bus.req_ready;
  assign offset = addr_q - BASE_ADDR;
  assign idx    = offset[AW+1:2];
  // BASE_ADDR is word aligned, so the low offset bits equal the address lane bits
  assign lane   = offset[1:0];
  assign commit = (state == ACCESS) && we_q && !err && !rst;

  always_comb begin
    err = 1'b0;
    if (addr_q < BASE_ADDR) err = 1'b1;
    if (offset[31:2] >= 30'(DEPTH)) err = 1'b1;
    case (size_q)
      2'b01:   if (lane[0]) err = 1'b1;
      2'b10:   if (lane != 2'b00) err = 1'b1;
      2'b11:   err = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata_q;
    case (size_q)
      2'b00: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // RAM has no reset: contents survive rst
  always_ff @(posedge clk) begin
    if (state == ACCESS) rd_word <= mem[idx];
    for (int k = 0; k < 4; k++) begin
      if (commit && be[k]) mem[idx][8*k +: 8] <= wdata_rep[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      size_q  <= bus.req_size;
      uns_q   <= bus.req_unsigned;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  always_comb begin
    byte_sel = rd_word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_data = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE) && !rst;
    bus.rsp_valid = (state == RESP);
    bus.rsp_err   = (state == RESP) && err;
    bus.rsp_rdata = ((state == RESP) && !err && !we_q) ? load_data : 32'h0;
  end
endmodule
